uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single 8N1 UART transmitter between NREQ byte-stream requesters
//   (e.g. SDIO bridge data path, debug/status printer). Round-robin arbitration
//   at packet granularity: the grant locks to one requester until it sends a
//   byte flagged last, so packets never interleave. Drives the transmitter's
//   FIFO write port (tx_dat/tx_en) and throttles on its full flag.
// PARAMETERS
//   NREQ   2      number of requesters, 2..4
//   TMO    1000   idle cycles (granted requester valid low) before a forced release; 0 = never
//   TMOW   16     width of the timeout counter; TMO < 2**TMOW
// PORTS
//   clk        in   1        system clock; all state on rising edge
//   rst        in   1        asynchronous reset, active-high
//   req_valid  in   NREQ     requester i presents a byte
//   req_data   in   8*NREQ   byte of requester i at [8*i+7:8*i]
//   req_last   in   NREQ     byte is last of requester i's packet
//   req_ready  out  NREQ     byte of requester i accepted this cycle (valid&ready)
//   tx_dat     out  8        byte to UART TX FIFO
//   tx_en      out  1        one-cycle write strobe to UART TX FIFO, active-high
//   tx_full    in   1        UART TX FIFO full
//   grant      out  NREQ     one-hot current owner; all-zero when idle
//   busy       out  1        a packet is locked
//   tmo_pulse  out  1        one-cycle pulse on forced timeout release
// BEHAVIOUR
//   Reset (async, any state): tx_en=0, tx_dat=0, grant=0, busy=0, tmo_pulse=0,
//     state=IDLE, timeout count=0, last_owner=NREQ-1 (so requester 0 wins first).
//   States: IDLE, LOCK.
//   IDLE: if any req_valid, owner = first i with req_valid scanning
//     last_owner+1, +2, ... mod NREQ; next cycle grant=onehot(owner), busy=1,
//     state=LOCK, count=0. No byte accepted in IDLE (1 cycle arbitration latency).
//   LOCK: req_ready[owner] = req_valid-independent comb of (!tx_full && !tx_en);
//     other req_ready bits 0. Accept = req_valid[owner] && req_ready[owner].
//     On accept: next cycle tx_en=1, tx_dat=req_data[owner]; count=0.
//     tx_en is 1 for exactly one cycle; never back-to-back (max 1 byte/2 clk),
//     which covers the one-cycle lag of the FIFO full flag.
//     Accept with req_last[owner]=1: last_owner=owner, state=IDLE, grant=0,
//       busy=0 next cycle; the tx_en strobe for that byte still issues.
//   Timeout: in LOCK, count increments each cycle req_valid[owner]=0; stalls
//     (valid=1, tx_full=1) hold count, do not increment. count==TMO-1 with
//     valid low -> next cycle state=IDLE, grant=0, busy=0, last_owner=owner,
//     tmo_pulse=1 for one cycle. TMO=0: counter disabled, lock held forever.
//   Simultaneous: requests arriving in the same cycle resolved by round-robin
//     order only; a requester dropping valid in IDLE before grant is not granted
//     (arbitration samples the cycle state leaves IDLE).
//   Release and new request same cycle: IDLE always spends one cycle, so a
//     released owner re-requesting waits behind any other valid requester.
//   tx_full high while tx_en pending: write still issued (FIFO flag was
//     low when accepted); no further accept until tx_full=0.
//   Widths: count saturates never (reset on accept or release); owner index
//     width clog2(NREQ), min 1.
// TESTING
//   Reset mid-packet (LOCK, tx_en=1) -> same cycle tx_en=0, grant=0, busy=0.
//   Req0 sends 3-byte packet 0x41,0x42,0x43(last), tx_full=0 -> tx_en pulses
//     every 2 clk, tx_dat in order, busy drops cycle after 0x43 accepted.
//   Req0 and Req1 both valid from reset -> grant 01 first; after req0 last,
//     grant 10; req0 packet bytes never appear between req1 bytes.
//   tx_full=1 for 20 cycles during LOCK with valid=1 -> no req_ready, no tx_en,
//     no tmo_pulse; byte accepted 1 cycle after tx_full falls.
//   TMO=8, owner drops valid mid-packet -> tmo_pulse after 8 idle cycles,
//     grant passes to the other valid requester.
//   NREQ=3, all valid continuously, 1-byte packets -> grant sequence 0,1,2,0,1,2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX FIFO write port
// between NREQ byte-stream requesters. One byte is written at most every
// other cycle so the FIFO's registered full flag is always up to date.
module uart_tx_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned TMO  = 1000,
    parameter int unsigned TMOW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_dat,
    output logic              tx_en,
    input  logic              tx_full,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              tmo_pulse
);

    localparam int unsigned     OW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [OW-1:0]   LastIdx = OW'(NREQ - 1);
    // Only meaningful when TMO != 0; the TMO == 0 wrap is never compared.
    localparam logic [TMOW-1:0] TmoLast = TMOW'(TMO - 1);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e            state_q;
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     last_owner_q;
    logic [TMOW-1:0]   count_q;
    logic [NREQ-1:0]   grant_q;
    logic              busy_q;
    logic              tx_en_q;
    logic [7:0]        tx_dat_q;
    logic              tmo_pulse_q;

    logic              own_valid;
    logic              own_last;
    logic              own_ready;
    logic              accept;
    logic [7:0]        own_data;
    logic              arb_found;
    logic [OW-1:0]     arb_idx;
    logic [OW-1:0]     arb_cand;
    logic [NREQ-1:0]   arb_onehot;

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_data  = req_data[{owner_q, 3'b000} +: 8];
    // The slot after a write is skipped, covering the full flag's one-cycle lag.
    assign own_ready = (state_q == StLock) && !tx_full && !tx_en_q;
    assign accept    = own_valid && own_ready;

    assign tx_en     = tx_en_q;
    assign tx_dat    = tx_dat_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign tmo_pulse = tmo_pulse_q;

    // Ready goes only to the current owner and never depends on its valid.
    always_comb begin
        req_ready          = '0;
        req_ready[owner_q] = own_ready;
    end

    // Round-robin pick: first valid requester after the previous owner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_owner_q;
        arb_cand  = last_owner_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_cand = (arb_cand == LastIdx) ? '0 : arb_cand + OW'(1);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
        arb_onehot = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
    end

    // Arbitration/lock FSM with registered FIFO strobe, grant and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= LastIdx;
            count_q      <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_dat_q     <= 8'h00;
            tmo_pulse_q  <= 1'b0;
        end else begin
            tx_en_q     <= 1'b0;
            tmo_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        owner_q <= arb_idx;
                        grant_q <= arb_onehot;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    if (accept) begin
                        tx_en_q  <= 1'b1;
                        tx_dat_q <= own_data;
                        count_q  <= '0;
                        if (own_last) begin
                            state_q      <= StIdle;
                            grant_q      <= '0;
                            busy_q       <= 1'b0;
                            last_owner_q <= owner_q;
                        end
                    end else if (!own_valid && (TMO != 0)) begin
                        // Stalls on tx_full keep valid high and so hold the count.
                        if (count_q == TmoLast) begin
                            state_q      <= StIdle;
                            grant_q      <= '0;
                            busy_q       <= 1'b0;
                            last_owner_q <= owner_q;
                            count_q      <= '0;
                            tmo_pulse_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + TMOW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three requesters and TMO=8.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_dat;
    logic              tx_en;
    logic              tx_full = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              tmo_pulse;

    uart_tx_arbiter #(
        .NREQ (NREQ),
        .TMO  (8),
        .TMOW (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_dat    (tx_dat),
        .tx_en     (tx_en),
        .tx_full   (tx_full),
        .grant     (grant),
        .busy      (busy),
        .tmo_pulse (tmo_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]      src_q[NREQ][$];  // {last, data} per requester
    logic [7:0]      exp_q[$];        // expected FIFO write order
    int              txcyc[$];
    logic            txbusy[$];
    logic [NREQ-1:0] gseq[$];
    int              tmocyc[$];
    logic [NREQ-1:0] acc;
    logic            prev_tx_en = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l, input logic expect_it);
        src_q[i].push_back({l, d});
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic clear_logs();
        txcyc.delete();
        txbusy.delete();
        gseq.delete();
        tmocyc.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Requester model: present queue heads, retire them on valid&ready.
    always begin
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            logic [8:0] e;
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                e = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_en) begin
                chk("tx_gap", {31'd0, prev_tx_en}, 0);
                chk("tx_rdy", {29'd0, req_ready}, 0);
                if (exp_q.size() == 0) chk("tx_unexp", {31'd0, tx_en}, 0);
                else chk("tx_dat", {24'd0, tx_dat}, {24'd0, exp_q.pop_front()});
                txcyc.push_back(cyc);
                txbusy.push_back(busy);
            end
            if (req_ready != '0) chk("rdy_owner", {29'd0, req_ready & ~grant}, 0);
            if (grant != '0 && grant != prev_grant) gseq.push_back(grant);
            if (tmo_pulse) tmocyc.push_back(cyc);
        end
        prev_tx_en = tx_en;
        prev_grant = grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        int viol;

        // Reset state
        tick(1);
        chk("rst_tx_en", {31'd0, tx_en}, 0);
        chk("rst_tx_dat", {24'd0, tx_dat}, 0);
        chk("rst_grant", {29'd0, grant}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tmo", {31'd0, tmo_pulse}, 0);
        chk("rst_ready", {29'd0, req_ready}, 0);
        rst = 1'b0;
        tick(1);

        // Single 3-byte packet from requester 0
        clear_logs();
        c0 = cyc;
        send(0, 8'h41, 1'b0, 1'b1);
        send(0, 8'h42, 1'b0, 1'b1);
        send(0, 8'h43, 1'b1, 1'b1);
        wait_drain("t2", 200);
        tick(2);
        chk("t2_ntx", txcyc.size(), 3);
        if (txcyc.size() == 3) begin
            chk("t2_first_lat", txcyc[0] - c0, 3);
            chk("t2_gap1", txcyc[1] - txcyc[0], 2);
            chk("t2_gap2", txcyc[2] - txcyc[1], 2);
            chk("t2_busy_mid", {31'd0, txbusy[1]}, 1);
            chk("t2_busy_last", {31'd0, txbusy[2]}, 0);
        end
        chk("t2_idle_busy", {31'd0, busy}, 0);

        // Two requesters from reset: packets never interleave, round-robin order
        reset_dut();
        clear_logs();
        send(0, 8'hA0, 1'b0, 1'b1);
        send(0, 8'hA1, 1'b1, 1'b1);
        send(1, 8'hB0, 1'b0, 1'b0);
        send(1, 8'hB1, 1'b1, 1'b0);
        send(0, 8'hA2, 1'b0, 1'b0);
        send(0, 8'hA3, 1'b1, 1'b0);
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        wait_drain("t3", 400);
        tick(2);
        chk("t3_ngrant", gseq.size(), 3);
        if (gseq.size() == 3) begin
            chk("t3_grant0", {29'd0, gseq[0]}, 1);
            chk("t3_grant1", {29'd0, gseq[1]}, 2);
            chk("t3_grant2", {29'd0, gseq[2]}, 1);
        end

        // tx_full stall for 20 cycles while locked with valid high
        reset_dut();
        clear_logs();
        tx_full = 1'b1;
        send(0, 8'hC0, 1'b1, 1'b1);
        tick(3);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != '0 || tx_en || tmo_pulse || !busy) viol++;
            tick(1);
        end
        chk("t4_stall", viol, 0);
        chk("t4_grant", {29'd0, grant}, 1);
        c0 = cyc;
        tx_full = 1'b0;
        #1;
        chk("t4_ready", {29'd0, req_ready}, 1);
        wait_drain("t4", 50);
        tick(2);
        chk("t4_ntmo", tmocyc.size(), 0);
        if (txcyc.size() == 1) chk("t4_lat", txcyc[0] - c0, 1);
        else chk("t4_ntx", txcyc.size(), 1);

        // Owner goes quiet mid-packet: forced release after 8 idle cycles
        reset_dut();
        clear_logs();
        send(0, 8'hD0, 1'b0, 1'b1);
        send(1, 8'hE0, 1'b1, 1'b1);
        wait_drain("t5", 200);
        tick(2);
        chk("t5_ntmo", tmocyc.size(), 1);
        if (tmocyc.size() == 1 && txcyc.size() == 2) chk("t5_tmo_lat", tmocyc[0] - txcyc[0], 8);
        else chk("t5_ntx", txcyc.size(), 2);
        chk("t5_ngrant", gseq.size(), 2);
        if (gseq.size() == 2) chk("t5_grant1", {29'd0, gseq[1]}, 2);

        // Three requesters, 1-byte packets: grant rotates 0,1,2,0,1,2
        reset_dut();
        clear_logs();
        send(0, 8'h10, 1'b1, 1'b0);
        send(0, 8'h11, 1'b1, 1'b0);
        send(1, 8'h20, 1'b1, 1'b0);
        send(1, 8'h21, 1'b1, 1'b0);
        send(2, 8'h30, 1'b1, 1'b0);
        send(2, 8'h31, 1'b1, 1'b0);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h31);
        wait_drain("t6", 300);
        tick(2);
        chk("t6_ngrant", gseq.size(), 6);
        if (gseq.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t6_grant", {29'd0, gseq[i]}, 32'(1) << (i % 3));
        end

        // Reset asserted mid-packet while the write strobe is high
        reset_dut();
        clear_logs();
        send(0, 8'hF0, 1'b0, 1'b0);
        send(0, 8'hF1, 1'b0, 1'b0);
        n = 0;
        while (!tx_en && n < 50) begin
            tick(1);
            n++;
        end
        chk("t7_seen", {31'd0, tx_en}, 1);
        chk("t7_dat", {24'd0, tx_dat}, 32'h0000_00F0);
        rst = 1'b1;
        #1;
        chk("t7_tx_en", {31'd0, tx_en}, 0);
        chk("t7_grant", {29'd0, grant}, 0);
        chk("t7_busy", {31'd0, busy}, 0);
        chk("t7_ready", {29'd0, req_ready}, 0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
